serial_add_sequencer: RTL and testbench
=======================================

// Module: serial_add_sequencer
// PURPOSE
//  Bit-serial adder controller that reuses a single 1-bit MUX full-adder cell across WIDTH cycles.
//  Accepts two WIDTH-bit operands plus carry-in over a valid/ready input handshake.
//  Steps the operands LSB-first through the cell and holds a registered carry between bits.
//  Returns the sum, carry-out and signed-overflow flag over a valid/ready output handshake.
//  Sits between operand producers and consumers, where area matters more than throughput.
// PARAMETERS
//  WIDTH   8   operand/sum width in bits; legal range 1..64
// PORTS
//  clk        in   1      single clock; all state updates on rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operand request valid
//  in_ready   out  1      block can accept operands (IDLE only)
//  a          in   WIDTH  operand A, sampled on input handshake
//  b          in   WIDTH  operand B, sampled on input handshake
//  cin        in   1      carry-in, sampled on input handshake
//  out_valid  out  1      result valid (DONE only)
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  registered result a+b+cin, modulo 2^WIDTH
//  cout       out  1      carry out of bit WIDTH-1
//  ovf        out  1      signed overflow = carry-into-MSB XOR carry-out-of-MSB
//  busy       out  1      high in RUN or DONE
// BEHAVIOUR
//  Reset (async, while rst=1)
//   - state=IDLE; sum=0, cout=0, ovf=0, out_valid=0, busy=0; shift regs, carry and bit counter = 0.
//   - in_ready=1 once rst deasserts.
//   - Reset mid-RUN or mid-DONE aborts the operation; the partial result is discarded and no out_valid pulse occurs.
//  FSM states: IDLE, RUN, DONE
//  IDLE
//   - in_ready=1.
//   - On edge with in_valid=1: latch a into a_sh, b into b_sh, cin into carry; bit counter=0; go to RUN.
//   - in_valid=0: stay in IDLE.
//  RUN
//   - in_ready=0; in_valid is ignored.
//   - Each edge feeds a_sh[0], b_sh[0], carry into the full-adder cell.
//   - Cell sum bit shifts into sum at the MSB (sum shifts right); a_sh and b_sh shift right; carry <= cell carry.
//   - Counter increments each edge.
//   - On the edge processing bit WIDTH-1:
//     - capture carry (carry into MSB) for ovf; cout <= cell carry;
//     - ovf <= carry XOR cell carry;
//     - go to DONE.
//  DONE
//   - out_valid=1; sum, cout and ovf are held stable until handshake.
//   - On edge with out_ready=1: go to IDLE.
//   - out_valid=0 the cycle after the handshake; sum, cout and ovf retain their values.
//   - in_ready rises in the same cycle out_valid falls.
//  Timing
//   - Input handshake at edge E. Bit i is processed at edge E+1+i.
//   - out_valid=1 from edge E+WIDTH.
//   - Minimum spacing between accepted operations is WIDTH+2 cycles.
//  Boundaries
//   - WIDTH=1: one RUN cycle; ovf = cin XOR cout of the single cell.
//   - out_ready held high: DONE lasts exactly 1 cycle.
//   - out_ready=1 while not in DONE: ignored.
//   - in_valid and out_ready both high in DONE: out handshake only; the input is taken in the next IDLE cycle.
//   - Counter width is $clog2(WIDTH)+1; no wrap is possible within an operation.
// TESTING
//  1. a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, ovf=0; out_valid at edge E+8.
//  2. a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, cout=0, ovf=1.
//  3. a=8'h80, b=8'h80, cin=1 -> sum=8'h01, cout=1, ovf=1.
//  4. out_ready=0 for 5 cycles in DONE -> out_valid, sum, cout, ovf stable; in_ready=0; new in_valid ignored.
//  5. rst pulsed at RUN bit 3 -> all outputs 0, state IDLE, no out_valid; next operation a=3, b=4 -> sum=7.
//  6. 1000 random (a, b, cin) with random out_ready -> sum/cout/ovf match golden {cout,sum}=a+b+cin;
//     check in_ready/out_valid protocol and WIDTH+2 spacing.

Source files
------------

// File: rtl/serial_add_sequencer.sv
// serial_add_sequencer
// Bit-serial adder: one MUX-based full-adder cell is reused for WIDTH cycles,
// operands are consumed LSB-first and the sum is assembled MSB-in, shifting right.
// Operands arrive over a valid/ready handshake; the result leaves over another.

module serial_add_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  // Counter is wide enough to hold WIDTH-1 without ever wrapping, even for WIDTH=1.
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            cell_p_s;
  logic            cell_sum_s;
  logic            cell_co_s;

  // Full-adder cell built from 2:1 muxes: propagate selects between carry and generate.
  function automatic logic [1:0] mux_full_add(input logic fa, input logic fb, input logic fc);
    logic p;
    logic s;
    logic co;
    p  = fa ^ fb;
    s  = fc ? ~p : p;
    co = p ? fc : fa;
    return {co, s};
  endfunction

  // Evaluate the shared cell on the current LSBs and the held carry.
  always_comb begin
    {cell_co_s, cell_sum_s} = mux_full_add(a_sh_q[0], b_sh_q[0], carry_q);
    cell_p_s = a_sh_q[0] ^ b_sh_q[0];
  end

  // Next-state and datapath control for the three-state sequencer.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // Operands shift right; new sum bit enters at the MSB so bit 0 lands last.
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        sum_d   = sum_q >> 1;
        sum_d[WIDTH-1] = cell_sum_s;
        carry_d = cell_co_s;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          // carry_q here is the carry into the MSB.
          cout_d  = cell_co_s;
          ovf_d   = carry_q ^ cell_co_s;
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake flags are pure decodes of the state register, so they are glitch-free.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q == RUN) || (state_q == DONE);
    sum       = sum_q;
    cout      = cout_q;
    ovf       = ovf_q;
  end

  // Propagate term is only observed inside the cell; keep it referenced.
  logic unused_s;
  assign unused_s = cell_p_s;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Self-checking bench for serial_add_sequencer: scoreboard of golden results,
// protocol monitor on the falling edge, directed corner cases and a random run.

module tb_serial_add_sequencer;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } res_t;

  res_t q[$];
  int   total;
  int   bad;
  int   cyc;
  int   acc_edge;
  int   last_acc;
  int   acc_cnt;
  logic         prev_ov;
  logic         prev_ordy;
  logic [W-1:0] prev_sum;
  logic         prev_cout;
  logic         prev_ovf;

  serial_add_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count rising edges so latency and spacing can be measured in cycles.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic res_t golden(input logic [W-1:0] ga, input logic [W-1:0] gb, input logic gc);
    logic [W:0] t;
    res_t r;
    t   = {1'b0, ga} + {1'b0, gb} + {{W{1'b0}}, gc};
    r.s = t[W-1:0];
    r.c = t[W];
    r.o = (ga[W-1] == gb[W-1]) && (t[W-1] != ga[W-1]);
    return r;
  endfunction

  // Protocol monitor and scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      prev_ov   <= 1'b0;
      prev_ordy <= 1'b0;
    end else begin
      chk("rdy_excl", {63'd0, in_ready & out_valid}, 64'd0);
      chk("busy", {63'd0, busy}, {63'd0, ~in_ready});
      if (out_valid && !prev_ov)
        chk("ov_latency", 64'(cyc - acc_edge), 64'(W));
      if (prev_ov && !prev_ordy) begin
        chk("hold_valid", {63'd0, out_valid}, 64'd1);
        chk("hold_sum", 64'(sum), 64'(prev_sum));
        chk("hold_cout", {63'd0, cout}, {63'd0, prev_cout});
        chk("hold_ovf", {63'd0, ovf}, {63'd0, prev_ovf});
      end
      if (in_valid && in_ready) begin
        if (last_acc >= 0)
          chk("spacing", {63'd0, (cyc + 1 - last_acc) >= W + 2}, 64'd1);
        acc_edge <= cyc + 1;
        last_acc <= cyc + 1;
        acc_cnt  <= acc_cnt + 1;
        q.push_back(golden(a, b, cin));
      end
      if (out_valid && out_ready) begin
        chk("sb_nonempty", {63'd0, q.size() != 0}, 64'd1);
        if (q.size() != 0) begin
          res_t e;
          e = q.pop_front();
          chk("sum", 64'(sum), 64'(e.s));
          chk("cout", {63'd0, cout}, {63'd0, e.c});
          chk("ovf", {63'd0, ovf}, {63'd0, e.o});
        end
      end
      prev_ov   <= out_valid;
      prev_ordy <= out_ready;
    end
    prev_sum  <= sum;
    prev_cout <= cout;
    prev_ovf  <= ovf;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    chk(tag, {63'd0, n < 200}, 64'd1);
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc);
    int n;
    a = ta;
    b = tb_;
    cin = tc;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    chk("accept_to", {63'd0, n < 50}, 64'd1);
    step();
    in_valid = 1'b0;
    wait_drain("drain_to");
  endtask

  initial begin
    int n;
    total = 0;
    bad = 0;
    acc_edge = 0;
    last_acc = -100;
    acc_cnt = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    #23;
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout", {63'd0, cout}, 64'd0);
    chk("rst_ovf", {63'd0, ovf}, 64'd0);
    chk("rst_ovalid", {63'd0, out_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    step();
    rst = 1'b0;
    step();
    chk("rst_inready", {63'd0, in_ready}, 64'd1);

    // Directed additions with the consumer always ready.
    out_ready = 1'b1;
    run_op(8'hFF, 8'h01, 1'b0);
    chk("t1_sum", 64'(sum), 64'h00);
    chk("t1_cout", {63'd0, cout}, 64'd1);
    chk("t1_ovf", {63'd0, ovf}, 64'd0);
    run_op(8'h7F, 8'h01, 1'b0);
    chk("t2_sum", 64'(sum), 64'h80);
    chk("t2_cout", {63'd0, cout}, 64'd0);
    chk("t2_ovf", {63'd0, ovf}, 64'd1);
    run_op(8'h80, 8'h80, 1'b1);
    chk("t3_sum", 64'(sum), 64'h01);
    chk("t3_cout", {63'd0, cout}, 64'd1);
    chk("t3_ovf", {63'd0, ovf}, 64'd1);

    // Back-pressure in DONE with a competing input request.
    out_ready = 1'b0;
    a = 8'h12;
    b = 8'h34;
    cin = 1'b1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    chk("t4_done_to", {63'd0, n < 50}, 64'd1);
    a = 8'h55;
    b = 8'h22;
    cin = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_ovalid", {63'd0, out_valid}, 64'd1);
      chk("t4_inready", {63'd0, in_ready}, 64'd0);
      chk("t4_sum", 64'(sum), 64'h47);
    end
    out_ready = 1'b1;
    step();
    chk("t4_ovalid_fall", {63'd0, out_valid}, 64'd0);
    chk("t4_inready_rise", {63'd0, in_ready}, 64'd1);
    chk("t4_sum_kept", 64'(sum), 64'h47);
    step();
    in_valid = 1'b0;
    chk("t4_taken", {63'd0, busy}, 64'd1);
    wait_drain("t4_drain");
    chk("t4b_sum", 64'(sum), 64'h77);

    // Reset pulse in the middle of RUN discards the operation.
    a = 8'hA5;
    b = 8'h3C;
    cin = 1'b1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    q.delete();
    #2;
    chk("t5_sum", 64'(sum), 64'd0);
    chk("t5_cout", {63'd0, cout}, 64'd0);
    chk("t5_ovf", {63'd0, ovf}, 64'd0);
    chk("t5_busy", {63'd0, busy}, 64'd0);
    chk("t5_ovalid", {63'd0, out_valid}, 64'd0);
    #1;
    rst = 1'b0;
    step();
    chk("t5_idle", {63'd0, in_ready}, 64'd1);
    for (int i = 0; i < 12; i++) begin
      step();
      chk("t5_no_ovalid", {63'd0, out_valid}, 64'd0);
    end
    run_op(8'd3, 8'd4, 1'b0);
    chk("t5_sum7", 64'(sum), 64'd7);

    // Random operands with random producer/consumer behaviour.
    n = 0;
    while (acc_cnt < 1008 && n < 60000) begin
      in_valid  = 1'($urandom_range(0, 1));
      a         = W'($urandom);
      b         = W'($urandom);
      cin       = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    chk("rand_budget", {63'd0, n < 60000}, 64'd1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain("rand_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
